// File: rtl/bpred_ctrl.sv
// Decode-stage branch predictor: 2-bit saturating counter table indexed by PC,
// in-flight guess tracking to execute, training with a one-cycle write bypass, and statistics.
module bpred_ctrl #(
    parameter int         INDEX_W  = 6,
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        d_en,
    input  logic [31:0] d_pc,
    input  logic        d_isbranch,
    output logic        d_guess_taken,
    input  logic        e_resolve,
    input  logic        e_taken,
    output logic        bfrome,
    output logic        miss_nt,
    output logic        bpu_ready,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_miss
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] sweep_idx;
    logic [1:0]         cnt_tbl [ENTRIES];

    logic [INDEX_W-1:0] idx_d;
    logic [1:0]         d_cnt, e_cnt, new_cnt;
    logic               run, res_valid;

    logic               e_vld, e_guess;
    logic [INDEX_W-1:0] e_idx;

    logic               wr_vld_p1;
    logic [INDEX_W-1:0] wr_idx_p1;
    logic [1:0]         wr_cnt_p1;

    logic               unused_pc_bits;

    function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (sweep_idx == INDEX_W'(ENTRIES - 1)) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                  sweep_idx <= '0;
        else if (state_q == S_INIT) sweep_idx <= sweep_idx + 1'b1;
    end

    assign run       = (state_q == S_RUN);
    assign bpu_ready = run;

    assign idx_d          = d_pc[INDEX_W+1:2];
    assign unused_pc_bits = ^{d_pc[31:INDEX_W+2], d_pc[1:0]};

    // Both lookups see a pending write before it lands in the table.
    assign d_cnt = (wr_vld_p1 && wr_idx_p1 == idx_d) ? wr_cnt_p1 : cnt_tbl[idx_d];
    assign e_cnt = (wr_vld_p1 && wr_idx_p1 == e_idx) ? wr_cnt_p1 : cnt_tbl[e_idx];

    assign d_guess_taken = run & d_isbranch & d_cnt[1];
    assign res_valid     = run & e_resolve & e_vld & ~flush;
    assign bfrome        = res_valid & e_guess & ~e_taken;
    assign miss_nt       = res_valid & ~e_guess & e_taken;
    assign new_cnt       = cnt_step(e_cnt, e_taken);

    // Table write stage: init sweep, otherwise commit the pending training write
    always_ff @(posedge clk) begin
        if (state_q == S_INIT)  cnt_tbl[sweep_idx] <= INIT_CNT;
        else if (wr_vld_p1)     cnt_tbl[wr_idx_p1] <= wr_cnt_p1;
    end

    // D->E tracking stage and pending-write capture
    always_ff @(posedge clk) begin
        if (rst) begin
            e_vld     <= 1'b0;
            wr_vld_p1 <= 1'b0;
        end else begin
            wr_vld_p1 <= res_valid;
            if (flush)          e_vld <= 1'b0;
            else if (d_en)      e_vld <= d_isbranch & run;
            else if (res_valid) e_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && d_en) begin
            e_guess <= d_guess_taken;
            e_idx   <= idx_d;
        end
        if (res_valid) begin
            wr_idx_p1 <= e_idx;
            wr_cnt_p1 <= new_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_miss     <= '0;
        end else if (res_valid) begin
            stat_branches <= sat_inc(stat_branches);
            if (bfrome | miss_nt) stat_miss <= sat_inc(stat_miss);
        end
    end

endmodule
